mux_stream_nto1: RTL



---
 rtl/mux_stream_nto1.sv | 95 +++++++++
 1 files changed

// File: rtl/mux_stream_nto1.sv
// Registered N-to-1 stream mux with valid/ready per channel.
// Selection is either an external index or a round-robin pointer.
module mux_stream_nto1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          s,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] fx;
  logic [SEL_W-1:0] hi;
  logic [SEL_W-1:0] lo;
  logic             fx_v;
  logic             hi_v;
  logic             lo_v;
  logic             gnt_v;
  logic             load;
  logic [WIDTH-1:0] gnt_data;

  assign load = ~out_valid | out_ready;

  // Descending scan leaves the lowest match: hi is the first valid at or
  // above ptr, lo the lowest valid overall (the wrap-around candidate).
  always_comb begin
    fx_v = 1'b0;
    fx   = '0;
    hi_v = 1'b0;
    hi   = '0;
    lo_v = 1'b0;
    lo   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (in_valid[k] && s == SEL_W'(k)) begin
        fx_v = 1'b1;
        fx   = SEL_W'(k);
      end
      if (in_valid[k] && SEL_W'(k) >= ptr) begin
        hi_v = 1'b1;
        hi   = SEL_W'(k);
      end
      if (in_valid[k]) begin
        lo_v = 1'b1;
        lo   = SEL_W'(k);
      end
    end
    gnt_v = mode ? (hi_v | lo_v) : fx_v;
    gnt   = mode ? (hi_v ? hi : lo) : fx;
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt == SEL_W'(k)) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
      end
      in_ready[k] = ~rst & load & gnt_v & (gnt == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gnt_v) begin
        out_data  <= gnt_data;
        out_ch    <= gnt;
        out_valid <= 1'b1;
        if (mode) begin
          ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
